// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_pkg
// Description : Shared CHIP-8 constants, framebuffer geometry, sprite-blitter
//               state encoding and framebuffer address helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_pkg;

  localparam int ADDR_W                = 12;
  localparam logic [ADDR_W-1:0] SCREEN_BASE = 12'h100;
  localparam int SCREEN_BYTES_PER_LINE = 8;
  localparam int SCREEN_LINES          = 32;
  localparam int ROW_W                 = $clog2(SCREEN_LINES);
  localparam int COL_W                 = $clog2(SCREEN_BYTES_PER_LINE);

  typedef enum logic [2:0] {
    GPU_IDLE      = 3'd0,
    GPU_RD_SPRITE = 3'd1,
    GPU_RD_LEFT   = 3'd2,
    GPU_WR_LEFT   = 3'd3,
    GPU_RD_RIGHT  = 3'd4,
    GPU_WR_RIGHT  = 3'd5
  } gpu_state_e;

  // Framebuffer byte address of (row, byte column). The framebuffer is a
  // packed 32x8 byte array, so the offset is simply {row, col}.
  function automatic logic [ADDR_W-1:0] screen_idx(
    input logic [ADDR_W-1:0] base,
    input logic [ROW_W-1:0]  row,
    input logic [COL_W-1:0]  col
  );
    return base + {{(ADDR_W-ROW_W-COL_W){1'b0}}, row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_gpu.sv
`default_nettype none
// ============================================================================
// Module      : chip8_gpu
// Description : CHIP-8 DRW sprite blitter. XORs n sprite rows from memory into
//               the 64x32 1bpp framebuffer held in the same memory, with
//               horizontal/vertical wrap, and reports pixel collision.
// Ports       : clk, rst_n            - clock, async active-low reset
//               draw, addr, lines,    - start pulse and draw operands
//               x, y                    (sampled only when idle)
//               busy, collision       - draw status
//               mem_read*, mem_write* - shared byte-wide memory requests
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_gpu #(
  parameter logic [11:0] SCREEN_BASE = chip8_pkg::SCREEN_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        draw,
  input  logic [11:0] addr,
  input  logic [3:0]  lines,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  output logic        busy,
  output logic        collision,
  output logic        mem_read,
  output logic [11:0] mem_read_idx,
  input  logic [7:0]  mem_read_byte,
  input  logic        mem_read_ack,
  output logic        mem_write,
  output logic [11:0] mem_write_idx,
  output logic [7:0]  mem_write_byte
);
  import chip8_pkg::*;

  gpu_state_e  r_state;
  gpu_state_e  w_state_nxt;

  logic        r_busy;
  logic        r_collision;
  logic [11:0] r_src;
  logic [3:0]  r_rows_left;
  logic [4:0]  r_row;
  logic [2:0]  r_col;
  logic [2:0]  r_shift;
  logic [7:0]  r_sprite;
  logic [7:0]  r_screen;

  logic        w_start;
  logic        w_row_done;
  logic        w_last_row;
  logic [15:0] w_s16;
  logic [11:0] w_left_idx;
  logic [11:0] w_right_idx;

  // busy is checked as well as the state so that the single idle cycle of a
  // zero-line draw still ignores a new draw pulse.
  assign w_start     = (r_state == GPU_IDLE) && !r_busy && draw;
  assign w_last_row  = (r_rows_left == 4'd1);
  assign w_s16       = {r_sprite, 8'h00} >> r_shift;
  assign w_left_idx  = screen_idx(SCREEN_BASE, r_row, r_col);
  // 3-bit column add wraps right edge back to byte 0 of the same line.
  assign w_right_idx = screen_idx(SCREEN_BASE, r_row, r_col + 3'd1);

  assign busy      = r_busy;
  assign collision = r_collision;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= GPU_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_row_done     = 1'b0;
    mem_read       = 1'b0;
    mem_read_idx   = 12'h000;
    mem_write      = 1'b0;
    mem_write_idx  = 12'h000;
    mem_write_byte = 8'h00;
    case (r_state)
      GPU_IDLE: begin
        if (w_start && (lines != 4'd0)) w_state_nxt = GPU_RD_SPRITE;
      end
      GPU_RD_SPRITE: begin
        mem_read     = !mem_read_ack;
        mem_read_idx = mem_read_ack ? 12'h000 : r_src;
        if (mem_read_ack) w_state_nxt = GPU_RD_LEFT;
      end
      GPU_RD_LEFT: begin
        mem_read     = !mem_read_ack;
        mem_read_idx = mem_read_ack ? 12'h000 : w_left_idx;
        if (mem_read_ack) w_state_nxt = GPU_WR_LEFT;
      end
      GPU_WR_LEFT: begin
        mem_write      = 1'b1;
        mem_write_idx  = w_left_idx;
        mem_write_byte = r_screen ^ w_s16[15:8];
        // Byte-aligned sprites never spill into the neighbouring byte.
        if (r_shift != 3'd0) w_state_nxt = GPU_RD_RIGHT;
        else                 w_row_done  = 1'b1;
      end
      GPU_RD_RIGHT: begin
        mem_read     = !mem_read_ack;
        mem_read_idx = mem_read_ack ? 12'h000 : w_right_idx;
        if (mem_read_ack) w_state_nxt = GPU_WR_RIGHT;
      end
      GPU_WR_RIGHT: begin
        mem_write      = 1'b1;
        mem_write_idx  = w_right_idx;
        mem_write_byte = r_screen ^ w_s16[7:0];
        w_row_done     = 1'b1;
      end
      default: w_state_nxt = GPU_IDLE;
    endcase
    if (w_row_done) w_state_nxt = w_last_row ? GPU_IDLE : GPU_RD_SPRITE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_collision <= 1'b0;
      r_src       <= 12'h000;
      r_rows_left <= 4'd0;
      r_row       <= 5'd0;
      r_col       <= 3'd0;
      r_shift     <= 3'd0;
      r_sprite    <= 8'h00;
      r_screen    <= 8'h00;
    end else begin
      case (r_state)
        GPU_IDLE: begin
          if (w_start) begin
            r_busy      <= 1'b1;
            r_collision <= 1'b0;
            r_src       <= addr;
            r_rows_left <= lines;
            r_row       <= y;
            r_col       <= x[5:3];
            r_shift     <= x[2:0];
          end else begin
            r_busy <= 1'b0;
          end
        end
        GPU_RD_SPRITE: if (mem_read_ack) r_sprite <= mem_read_byte;
        GPU_RD_LEFT:   if (mem_read_ack) r_screen <= mem_read_byte;
        GPU_RD_RIGHT:  if (mem_read_ack) r_screen <= mem_read_byte;
        GPU_WR_LEFT:   r_collision <= r_collision | (|(r_screen & w_s16[15:8]));
        GPU_WR_RIGHT:  r_collision <= r_collision | (|(r_screen & w_s16[7:0]));
        default: ;
      endcase
      if (w_row_done) begin
        if (w_last_row) begin
          r_busy <= 1'b0;
        end else begin
          r_src       <= r_src + 12'd1;
          r_row       <= r_row + 5'd1;
          r_rows_left <= r_rows_left - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_gpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_gpu
// Description : Self-checking bench for chip8_gpu. Provides a byte memory
//               with a one-cycle read acknowledge and compares the resulting
//               framebuffer, collision flag and busy duration against a
//               pixel-level reference model.
// Ports       : none (testbench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_gpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        draw;
  logic [11:0] addr;
  logic [3:0]  lines;
  logic [5:0]  x;
  logic [4:0]  y;
  logic        busy;
  logic        collision;
  logic        mem_read;
  logic [11:0] mem_read_idx;
  logic [7:0]  mem_read_byte = 8'h00;
  logic        mem_read_ack  = 1'b0;
  logic        mem_write;
  logic [11:0] mem_write_idx;
  logic [7:0]  mem_write_byte;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem     [4096];
  logic [7:0] ref_mem [4096];

  int rd_cycles = 0;
  int wr_cycles = 0;
  int both_cnt  = 0;
  int idx_bad   = 0;

  chip8_gpu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .draw           (draw),
    .addr           (addr),
    .lines          (lines),
    .x              (x),
    .y              (y),
    .busy           (busy),
    .collision      (collision),
    .mem_read       (mem_read),
    .mem_read_idx   (mem_read_idx),
    .mem_read_byte  (mem_read_byte),
    .mem_read_ack   (mem_read_ack),
    .mem_write      (mem_write),
    .mem_write_idx  (mem_write_idx),
    .mem_write_byte (mem_write_byte)
  );

  always #5 clk = ~clk;

  // Memory: request sampled at an edge, data + ack in the following cycle.
  always @(posedge clk) begin
    mem_read_ack  <= mem_read;
    mem_read_byte <= mem_read ? mem[mem_read_idx] : 8'h00;
    if (mem_write) mem[mem_write_idx] <= mem_write_byte;
  end

  // Bus activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read)  rd_cycles++;
      if (mem_write) wr_cycles++;
      if (mem_read && mem_write) both_cnt++;
      if (!mem_read  && mem_read_idx  != 12'h000) idx_bad++;
      if (!mem_write && mem_write_idx != 12'h000) idx_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: toggle each lit sprite pixel at its wrapped screen position.
  task automatic model_draw(input logic [11:0] a, input int n, input int xx, input int yy,
                            output bit col);
    logic [7:0] sb;
    int px, py, ad, bi;
    col = 1'b0;
    for (int r = 0; r < n; r++) begin
      sb = ref_mem[(a + r) & 12'hFFF];
      for (int b = 0; b < 8; b++) begin
        if (sb[7-b]) begin
          px = (xx + b) % 64;
          py = (yy + r) % 32;
          ad = 256 + py * 8 + px / 8;
          bi = 7 - (px % 8);
          if (ref_mem[ad][bi]) col = 1'b1;
          ref_mem[ad][bi] = ~ref_mem[ad][bi];
        end
      end
    end
  endtask

  // Issue one draw and count busy cycles; optionally pulse draw (with
  // different operands) during the first busy cycle.
  task automatic run_draw(input logic [11:0] a, input logic [3:0] n, input logic [5:0] xx,
                          input logic [4:0] yy, input bit poke, output int cyc);
    @(negedge clk);
    addr = a; lines = n; x = xx; y = yy; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      cyc++;
      draw = poke && (cyc == 1);
      if (draw) begin
        addr = 12'($urandom); x = 6'($urandom); y = 5'($urandom); lines = 4'($urandom_range(1, 15));
      end
      @(negedge clk);
    end
    draw = 1'b0;
  endtask

  task automatic draw_and_check(input string tag, input logic [11:0] a, input logic [3:0] n,
                                input logic [5:0] xx, input logic [4:0] yy, input bit poke);
    bit ecol;
    int cyc, rd0, wr0, exp_cyc, exp_rd, exp_wr;
    rd0 = rd_cycles;
    wr0 = wr_cycles;
    model_draw(a, n, xx, yy, ecol);
    run_draw(a, n, xx, yy, poke, cyc);
    exp_cyc = (n == 0) ? 1 : n * (((xx % 8) == 0) ? 5 : 8);
    exp_rd  = n * (((xx % 8) == 0) ? 2 : 3);
    exp_wr  = n * (((xx % 8) == 0) ? 1 : 2);
    check({tag, "_busy_cycles"}, cyc, exp_cyc);
    check({tag, "_collision"}, collision, ecol);
    check({tag, "_reads"}, rd_cycles - rd0, exp_rd);
    check({tag, "_writes"}, wr_cycles - wr0, exp_wr);
    check({tag, "_rd_wr_overlap"}, both_cnt, 0);
    check({tag, "_idle_idx"}, idx_bad, 0);
    @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      if (mem[i] !== ref_mem[i]) check({tag, "_mem"}, {20'h0, i[11:0]}, 32'hFFFF_FFFF);
    end
    check({tag, "_screen_0x100"}, mem[256], ref_mem[256]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    draw  = 1'b0;
    addr  = 12'h000;
    lines = 4'd0;
    x     = 6'd0;
    y     = 5'd0;
    for (int i = 0; i < 4096; i++) mem[i] = ((i >= 256) && (i < 512)) ? 8'h00 : 8'($urandom);
    mem[12'h300] = 8'hF0;
    mem[12'h310] = 8'hFF;
    mem[12'h311] = 8'hFF;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_collision", collision, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_idx", {mem_read_idx, mem_write_idx, mem_write_byte}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    draw_and_check("t1", 12'h300, 4'd1, 6'd0, 5'd0, 1'b0);
    check("t1_byte100", mem[12'h100], 8'hF0);
    check("t1_col", collision, 1'b0);

    draw_and_check("t2", 12'h300, 4'd1, 6'd0, 5'd0, 1'b0);
    check("t2_byte100", mem[12'h100], 8'h00);
    check("t2_col", collision, 1'b1);

    draw_and_check("t3", 12'h310, 4'd1, 6'd3, 5'd2, 1'b0);
    check("t3_byte110", mem[12'h110], 8'h1F);
    check("t3_byte111", mem[12'h111], 8'hE0);
    check("t3_col", collision, 1'b0);

    draw_and_check("t4", 12'h310, 4'd2, 6'd60, 5'd31, 1'b0);
    check("t4_byte1ff", mem[12'h1FF], 8'h0F);
    check("t4_byte1f8", mem[12'h1F8], 8'hF0);
    check("t4_byte107", mem[12'h107], 8'h0F);
    check("t4_byte100", mem[12'h100], 8'hF0);

    draw_and_check("t5_zero", 12'h310, 4'd0, 6'd7, 5'd3, 1'b1);
    check("t5_col", collision, 1'b0);
    repeat (2) @(negedge clk);
    check("t5_still_idle", busy, 1'b0);

    draw_and_check("t6_poke", 12'h310, 4'd2, 6'd12, 5'd9, 1'b1);

    // Reset in the middle of a row, before any write of that draw.
    @(negedge clk);
    addr = 12'h310; lines = 4'd1; x = 6'd5; y = 5'd0; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (2) @(negedge clk);
    check("t7_pre_rst_read", mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_read", mem_read, 1'b0);
    check("t7_rst_write", mem_write, 1'b0);
    check("t7_rst_idx", mem_read_idx, 12'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_after_busy", busy, 1'b0);
    draw_and_check("t7_next", 12'h310, 4'd1, 6'd5, 5'd0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      draw_and_check("rnd", 12'($urandom_range(12'h200, 12'hFFF)), 4'($urandom_range(0, 15)),
                     6'($urandom), 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
